vram_port_arbiter: RTL and testbench

//  Shares one single-port VRAM (1-cycle registered read) between three users:

---
 rtl/vram_port_arbiter_if.sv | 32 +++
 rtl/vram_port_arbiter.sv | 110 +++++++++++
 tb/tb_vram_port_arbiter.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/vram_port_arbiter_if.sv
// Handshake and VRAM-side signals of the VRAM port arbiter.
// master = users plus RAM (drive requests and read data), slave = arbiter.
`timescale 1ns/1ps
interface vram_port_arbiter_if #(
    parameter int AW = 17
);
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_gnt;
    logic          rd_valid;
    logic [15:0]   rd_data;
    logic          wr_valid;
    logic [AW-1:0] wr_addr;
    logic [15:0]   wr_data;
    logic          wr_ready;
    logic          clear_req;
    logic [15:0]   clear_color;
    logic          clear_busy;
    logic [AW-1:0] mem_addr;
    logic          mem_wr_ena;
    logic [15:0]   mem_wr_data;
    logic [15:0]   mem_rd_data;

    modport master (
        output rd_req, rd_addr, wr_valid, wr_addr, wr_data, clear_req, clear_color, mem_rd_data,
        input  rd_gnt, rd_valid, rd_data, wr_ready, clear_busy, mem_addr, mem_wr_ena, mem_wr_data
    );
    modport slave (
        input  rd_req, rd_addr, wr_valid, wr_addr, wr_data, clear_req, clear_color, mem_rd_data,
        output rd_gnt, rd_valid, rd_data, wr_ready, clear_busy, mem_addr, mem_wr_ena, mem_wr_data
    );
endinterface

// File: rtl/vram_port_arbiter.sv
// Single-port VRAM arbiter: display reads first, sketch writes get a forced slot
// after MAX_RD_STREAK reads, and a clear engine fills VRAM in read-idle cycles.
`timescale 1ns/1ps
module vram_port_arbiter #(
    parameter int VRAM_L        = 76800,
    parameter int AW            = $clog2(VRAM_L),
    parameter int MAX_RD_STREAK = 8
) (
    input logic                clk,
    input logic                rst,
    vram_port_arbiter_if.slave bus
);
    localparam int            SW         = $clog2(MAX_RD_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_RD_STREAK);
    localparam logic [AW-1:0] LAST_ADDR  = AW'(VRAM_L - 1);
    // One extra bit so VRAM_L == 2**AW still compares correctly
    localparam logic [AW:0]   VL         = (AW+1)'(VRAM_L);

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t        state, state_nxt;
    logic [SW-1:0] streak, streak_nxt;
    logic [AW-1:0] clear_ptr, clear_ptr_nxt;
    logic [15:0]   clear_color_q, clear_color_nxt;
    logic [AW-1:0] addr_q, mem_addr;
    logic [15:0]   wdata_q, mem_wr_data;
    logic          mem_wr_ena;
    logic          rd_valid_q, rd_oob_q;
    logic          forced, rd_gnt, wr_gnt, clr_gnt, rd_in, wr_in;

    assign rd_in = {1'b0, bus.rd_addr} < VL;
    assign wr_in = {1'b0, bus.wr_addr} < VL;

    always_comb begin
        forced = bus.wr_valid && (streak == STREAK_MAX) && (state == S_IDLE);
        rd_gnt = bus.rd_req && !forced && !rst;
        wr_gnt = (forced || (bus.wr_valid && !bus.rd_req && state == S_IDLE)) && !rst;
        clr_gnt = (state == S_CLEAR) && !bus.rd_req && !rst;

        // Address/data hold their last value when no access is made
        mem_addr    = addr_q;
        mem_wr_data = wdata_q;
        mem_wr_ena  = 1'b0;
        if (rd_gnt) begin
            if (rd_in) mem_addr = bus.rd_addr;
        end else if (wr_gnt) begin
            if (wr_in) begin
                mem_addr    = bus.wr_addr;
                mem_wr_data = bus.wr_data;
                mem_wr_ena  = 1'b1;
            end
        end else if (clr_gnt) begin
            mem_addr    = clear_ptr;
            mem_wr_data = clear_color_q;
            mem_wr_ena  = 1'b1;
        end
    end

    always_comb begin
        state_nxt       = state;
        clear_ptr_nxt   = clear_ptr;
        clear_color_nxt = clear_color_q;
        streak_nxt      = streak;
        case (state)
            S_IDLE: if (bus.clear_req) begin
                state_nxt       = S_CLEAR;
                clear_ptr_nxt   = '0;
                clear_color_nxt = bus.clear_color;
            end
            S_CLEAR: if (clr_gnt) begin
                clear_ptr_nxt = clear_ptr + 1'b1;
                if (clear_ptr == LAST_ADDR) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (!bus.wr_valid || wr_gnt) streak_nxt = '0;
        else if (rd_gnt && streak != STREAK_MAX) streak_nxt = streak + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            streak        <= '0;
            clear_ptr     <= '0;
            clear_color_q <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            rd_valid_q    <= 1'b0;
            rd_oob_q      <= 1'b0;
        end else begin
            state         <= state_nxt;
            streak        <= streak_nxt;
            clear_ptr     <= clear_ptr_nxt;
            clear_color_q <= clear_color_nxt;
            addr_q        <= mem_addr;
            wdata_q       <= mem_wr_data;
            rd_valid_q    <= rd_gnt;
            rd_oob_q      <= !rd_in;
        end
    end

    assign bus.rd_gnt      = rd_gnt;
    assign bus.wr_ready    = wr_gnt;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.rd_data     = rd_oob_q ? 16'h0000 : bus.mem_rd_data;
    assign bus.clear_busy  = (state == S_CLEAR);
    assign bus.mem_addr    = mem_addr;
    assign bus.mem_wr_ena  = mem_wr_ena;
    assign bus.mem_wr_data = mem_wr_data;
endmodule

// File: tb/tb_vram_port_arbiter.sv
// Bench for vram_port_arbiter: directed scenarios plus a per-cycle reference model
// of the grant priorities, streak rule, clear engine and VRAM contents.
`timescale 1ns/1ps
module tb_vram_port_arbiter;
    localparam int VL  = 64;
    localparam int MSR = 4;
    localparam int AW  = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vram_port_arbiter_if #(.AW(AW)) bus ();

    vram_port_arbiter #(.VRAM_L(VL), .AW(AW), .MAX_RD_STREAK(MSR)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    // Behavioural block RAM: 1-cycle registered read
    logic [15:0] ram [VL];
    logic [15:0] ram_q;
    always @(posedge clk) begin
        if (bus.mem_wr_ena && bus.mem_addr < AW'(VL)) ram[bus.mem_addr[5:0]] <= bus.mem_wr_data;
        ram_q <= (bus.mem_addr < AW'(VL)) ? ram[bus.mem_addr[5:0]] : 16'hDEAD;
    end
    assign bus.mem_rd_data = ram_q;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference model state
    logic [15:0] m_mem [VL];
    bit          m_busy;
    int          m_ptr;
    logic [15:0] m_color;
    int          m_streak;
    bit          exp_rv;
    logic [15:0] exp_rd;

    always @(negedge clk) begin
        bit e_rd, e_wr, e_clr, forced, we;
        if (rst) begin
            check("rst_rd_gnt", bus.rd_gnt, 0);
            check("rst_wr_ready", bus.wr_ready, 0);
            check("rst_mem_wr_ena", bus.mem_wr_ena, 0);
            check("rst_rd_valid", bus.rd_valid, 0);
            check("rst_clear_busy", bus.clear_busy, 0);
            m_busy = 0; m_ptr = 0; m_streak = 0; exp_rv = 0;
        end else begin
            // Priority: starved write, then read, then clear, then ordinary write
            forced = bus.wr_valid && m_streak >= MSR && !m_busy;
            e_rd   = bus.rd_req && !forced;
            e_wr   = forced || (bus.wr_valid && !m_busy && !bus.rd_req);
            e_clr  = m_busy && !bus.rd_req;
            we     = (e_wr && bus.wr_addr < VL) || e_clr;
            check("m_rd_gnt", bus.rd_gnt, e_rd);
            check("m_wr_ready", bus.wr_ready, e_wr);
            check("m_clear_busy", bus.clear_busy, m_busy);
            check("m_rd_valid", bus.rd_valid, exp_rv);
            if (exp_rv) check("m_rd_data", bus.rd_data, exp_rd);
            check("m_mem_wr_ena", bus.mem_wr_ena, we);
            if (e_rd && bus.rd_addr < VL) check("m_rd_addr", bus.mem_addr, bus.rd_addr);
            if (we) begin
                check("m_wr_addr", bus.mem_addr, e_clr ? m_ptr : bus.wr_addr);
                check("m_wr_data", bus.mem_wr_data, e_clr ? m_color : bus.wr_data);
            end
            if (!bus.wr_valid || e_wr) m_streak = 0;
            else if (e_rd && m_streak < MSR) m_streak++;
            exp_rv = e_rd;
            exp_rd = (bus.rd_addr < VL) ? m_mem[bus.rd_addr[5:0]] : 16'h0000;
            if (e_wr && bus.wr_addr < VL) m_mem[bus.wr_addr[5:0]] = bus.wr_data;
            if (e_clr) begin
                m_mem[m_ptr] = m_color;
                if (m_ptr == VL - 1) m_busy = 0;
                else m_ptr++;
            end else if (!m_busy && bus.clear_req) begin
                m_busy = 1; m_ptr = 0; m_color = bus.clear_color;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int nrd, cnt, cnt_wr, ngnt;
        bit got;
        for (int i = 0; i < VL; i++) begin
            ram[i]   = 16'h1000 + 16'(i);
            m_mem[i] = 16'h1000 + 16'(i);
        end
        bus.rd_req = 1'b1; bus.rd_addr = '0;
        bus.wr_valid = 1'b1; bus.wr_addr = '0; bus.wr_data = '0;
        bus.clear_req = 1'b0; bus.clear_color = '0;
        repeat (3) @(negedge clk);
        check("reset_rd_gnt", bus.rd_gnt, 0);
        check("reset_wr_ready", bus.wr_ready, 0);
        cyc();
        bus.rd_req = 1'b0; bus.wr_valid = 1'b0;
        rst = 1'b0;

        // 1: write then read back the same word
        cyc(); bus.wr_valid = 1; bus.wr_addr = 5; bus.wr_data = 16'hF800;
        @(negedge clk); check("t1_wr_ready", bus.wr_ready, 1);
        cyc(); bus.wr_valid = 0; bus.rd_req = 1; bus.rd_addr = 5;
        @(negedge clk); check("t1_rd_gnt", bus.rd_gnt, 1);
        cyc(); bus.rd_req = 0;
        @(negedge clk);
        check("t1_rd_valid", bus.rd_valid, 1);
        check("t1_rd_data", bus.rd_data, 16'hF800);

        // 2: continuous reads starve a write for exactly MSR grants, twice
        for (int r = 0; r < 2; r++) begin
            nrd = 0; got = 0;
            cyc(); bus.rd_req = 1; bus.rd_addr = AW'(10 + r);
            bus.wr_valid = 1; bus.wr_addr = 9; bus.wr_data = 16'h1234 + 16'(r);
            for (int k = 0; k < 20 && !got; k++) begin
                if (k > 0) cyc();
                @(negedge clk);
                if (bus.wr_ready) got = 1;
                else if (bus.rd_gnt) nrd++;
            end
            check("t2_reads_before_wr", nrd, 4);
            check("t2_wr_accepted", got, 1);
            cyc(); bus.wr_valid = 0;
            @(negedge clk); check("t2_rd_resume", bus.rd_gnt, 1);
        end
        cyc(); bus.rd_req = 0;

        // 3: clear with no reads; a pending out-of-range write is locked out
        cyc(); bus.clear_req = 1; bus.clear_color = 16'h001F;
        bus.wr_valid = 1; bus.wr_addr = 100; bus.wr_data = 16'hAAAA;
        @(negedge clk); check("t3_wr_same_cycle", bus.wr_ready, 1);
        cnt = 0; cnt_wr = 0;
        for (int k = 0; k < 300; k++) begin
            cyc(); bus.clear_req = 0;
            @(negedge clk);
            if (!bus.clear_busy) break;
            cnt++;
            if (bus.wr_ready) cnt_wr++;
        end
        check("t3_busy_cycles", cnt, 64);
        check("t3_wr_ready_in_clear", cnt_wr, 0);
        cyc(); bus.wr_valid = 0;
        for (int i = 0; i < VL; i++) begin
            cyc(); bus.rd_req = 1; bus.rd_addr = AW'(i);
            cyc(); bus.rd_req = 0;
            @(negedge clk); check("t3_readback", bus.rd_data, 16'h001F);
        end

        // 4: clear interleaved with reads on alternate cycles
        cyc(); bus.clear_req = 1; bus.clear_color = 16'h07E0;
        cnt = 0; ngnt = 0;
        for (int k = 0; k < 400; k++) begin
            cyc(); bus.clear_req = 0;
            bus.rd_req = (k % 2 == 0); bus.rd_addr = AW'((k * 7) % VL);
            @(negedge clk);
            if (!bus.clear_busy) break;
            cnt++;
            if (bus.rd_gnt) ngnt++;
        end
        check("t4_busy_cycles", cnt, 128);
        check("t4_reads_granted", ngnt, 64);
        cyc(); bus.rd_req = 0;

        // 5: out-of-range read and write
        cyc(); bus.rd_req = 1; bus.rd_addr = 70;
        @(negedge clk);
        check("t5_rd_gnt", bus.rd_gnt, 1);
        check("t5_rd_no_wr", bus.mem_wr_ena, 0);
        cyc(); bus.rd_req = 0; bus.wr_valid = 1; bus.wr_addr = 100; bus.wr_data = 16'hBEEF;
        @(negedge clk);
        check("t5_rd_valid", bus.rd_valid, 1);
        check("t5_rd_data", bus.rd_data, 0);
        check("t5_wr_ready", bus.wr_ready, 1);
        check("t5_wr_dropped", bus.mem_wr_ena, 0);
        cyc(); bus.wr_valid = 0; bus.rd_req = 1; bus.rd_addr = 36;
        cyc(); bus.rd_req = 0;
        @(negedge clk); check("t5_alias_untouched", bus.rd_data, 16'h07E0);

        // 6: reset lands mid-clear with clear_ptr at 20
        cyc(); bus.clear_req = 1; bus.clear_color = 16'hF81F;
        cnt = 0;
        for (int k = 0; k < 100 && cnt < 20; k++) begin
            cyc(); bus.clear_req = 0;
            @(negedge clk);
            if (bus.clear_busy) cnt++;
        end
        cyc(); bus.rd_req = 1; bus.rd_addr = 3;
        cyc(); bus.rd_req = 0;
        check("t6_rd_valid_before", bus.rd_valid, 1);
        rst = 1;
        #1;
        check("t6_busy_after_rst", bus.clear_busy, 0);
        check("t6_rd_valid_after_rst", bus.rd_valid, 0);
        cyc(); cyc(); rst = 0;
        cyc();
        @(negedge clk); check("t6_busy_stays_low", bus.clear_busy, 0);
        for (int i = 0; i < VL; i++) begin
            cyc(); bus.rd_req = 1; bus.rd_addr = AW'(i);
            cyc(); bus.rd_req = 0;
            @(negedge clk);
            check("t6_partial", bus.rd_data, (i < 20) ? 16'hF81F : 16'h07E0);
        end

        repeat (3) cyc();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
